// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / PS-2 keyboard) arbiter for one shared synchronous RAM.
// Ports:
//   CLOCK_50, RESET_N                 - system clock, async active-low reset
//   CPU_REQ/WE/ADDR/WDATA -> RDATA/ACK - core access port (level request, 1-cycle ACK)
//   KB_REQ/WE/ADDR/WDATA  -> RDATA/ACK - keyboard access port, same handshake
//   RAM_ADDR/RAM_D/RAM_WE, RAM_Q      - shared RAM, Q valid one cycle after address
//   BUSY, GRANT_KB                    - FSM not idle / current owner is keyboard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic [15:0] CPU_RDATA,
  output logic        CPU_ACK,
  input  logic        KB_REQ,
  input  logic        KB_WE,
  input  logic [15:0] KB_ADDR,
  input  logic [15:0] KB_WDATA,
  output logic [15:0] KB_RDATA,
  output logic        KB_ACK,
  output logic [15:0] RAM_ADDR,
  output logic [15:0] RAM_D,
  output logic        RAM_WE,
  input  logic [15:0] RAM_Q,
  output logic        BUSY,
  output logic        GRANT_KB
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  logic [1:0]  r_state;
  logic        r_kb;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_d;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_kb_rdata;
  logic [3:0]  r_starve;
  logic        w_grant;
  logic        w_grant_kb;
  // KB wins only when it is the sole requester or the CPU has starved it long enough.
  always_comb begin
    w_grant    = CPU_REQ | KB_REQ;
    w_grant_kb = KB_REQ & (~CPU_REQ | (r_starve >= LIMIT));
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_kb        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_d         <= '0;
      r_cpu_rdata <= '0;
      r_kb_rdata  <= '0;
      r_starve    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Counter only moves in IDLE; an idle KB port or a KB grant clears it.
          r_starve <= (!KB_REQ || w_grant_kb) ? 4'd0 :
                      (r_starve >= LIMIT) ? r_starve : r_starve + 4'd1;
          if (w_grant) begin
            r_state <= S_ACCESS;
            r_kb    <= w_grant_kb;
            r_we    <= w_grant_kb ? KB_WE : CPU_WE;
            r_addr  <= w_grant_kb ? KB_ADDR : CPU_ADDR;
            r_d     <= w_grant_kb ? KB_WDATA : CPU_WDATA;
          end
        end
        S_ACCESS: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_state <= S_DONE;
          if (!r_we && r_kb) r_kb_rdata <= RAM_Q;
          if (!r_we && !r_kb) r_cpu_rdata <= RAM_Q;
        end
        default: begin
          // Leaving DONE: drop the bus so RAM_ADDR/RAM_D read 0 in IDLE.
          r_state <= S_IDLE;
          r_kb    <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_d     <= '0;
        end
      endcase
    end
  end
  assign RAM_ADDR  = r_addr;
  assign RAM_D     = r_d;
  assign RAM_WE    = (r_state == S_ACCESS) & r_we;
  assign CPU_ACK   = (r_state == S_DONE) & ~r_kb;
  assign KB_ACK    = (r_state == S_DONE) & r_kb;
  assign CPU_RDATA = r_cpu_rdata;
  assign KB_RDATA  = r_kb_rdata;
  assign BUSY      = r_state != S_IDLE;
  assign GRANT_KB  = r_kb;
endmodule
